// File: rtl/refill_ctrl.sv
// Cache line refill controller: picks a victim way on a miss, bursts the line in
// from memory into the data array, then marks the filled way MRU in the PLRU generator.
module refill_ctrl #(
  parameter int SET_ASSOC  = 4,
  parameter int LINE_WORDS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hit_valid,
  input  logic [SET_ASSOC-1:0]          hit_way,
  input  logic                          miss_req,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  input  logic [SET_ASSOC-1:0]          set_valid,
  output logic                          miss_ready,
  input  logic [$clog2(SET_ASSOC)-1:0]  repl_index,
  output logic [SET_ASSOC-1:0]          plru_access,
  output logic                          plru_update,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_ready,
  input  logic                          mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_rlast,
  output logic                          fill_we,
  output logic [$clog2(SET_ASSOC)-1:0]  fill_way,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic [DATA_WIDTH-1:0]         fill_data,
  output logic                          refill_done,
  output logic                          refill_err,
  output logic [1:0]                    dbg_state
);

  localparam int WAY_W  = $clog2(SET_ASSOC);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_COMMIT} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WAY_W-1:0]      r_victim;
  logic [WORD_W-1:0]     r_cnt;
  logic                  r_err;
  logic                  r_miss_ready;
  logic                  r_mem_req;
  logic                  r_done;

  logic [WAY_W-1:0]      w_victim;
  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic                  w_beat;
  logic                  w_last_beat;
  logic [SET_ASSOC-1:0]  w_victim_oh;

  // Lowest-index invalid way wins; a full set falls back to the generator's pick.
  always_comb begin
    w_victim = repl_index;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!set_valid[i]) w_victim = WAY_W'(i);
    end
  end

  assign w_addr_aligned = miss_addr & ~ADDR_WIDTH'((1 << OFF_W) - 1);
  assign w_beat         = (r_state == S_RECV) && mem_rvalid;
  assign w_last_beat    = (r_cnt == WORD_W'(LINE_WORDS - 1));
  assign w_victim_oh    = SET_ASSOC'(1) << r_victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_victim     <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_miss_ready <= 1'b1;
      r_mem_req    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            r_mem_addr   <= w_addr_aligned;
            r_victim     <= w_victim;
            r_cnt        <= '0;
            r_miss_ready <= 1'b0;
            r_mem_req    <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_beat) begin
            r_cnt <= r_cnt + WORD_W'(1);
            // A beat count that disagrees with rlast in either direction ends the burst.
            if (mem_rlast || w_last_beat) begin
              if (mem_rlast != w_last_beat) r_err <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_COMMIT;
            end
          end
        end
        default: begin
          r_done       <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // The commit update owns the generator port; a coincident hit is dropped.
  always_comb begin
    plru_access = hit_way;
    plru_update = hit_valid;
    if (r_done) begin
      plru_access = w_victim_oh;
      plru_update = 1'b1;
    end
  end

  assign miss_ready  = r_miss_ready;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign fill_we     = w_beat;
  assign fill_way    = r_victim;
  assign fill_word   = r_cnt;
  assign fill_data   = w_beat ? mem_rdata : '0;
  assign refill_done = r_done;
  assign refill_err  = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_refill_ctrl.sv
// Directed testbench for refill_ctrl: victim choice, burst fill, backpressure,
// hit forwarding, burst-length errors and asynchronous reset mid-burst.
module tb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hit_valid;
  logic [3:0]  hit_way;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic [3:0]  set_valid;
  logic        miss_ready;
  logic [1:0]  repl_index;
  logic [3:0]  plru_access;
  logic        plru_update;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        fill_we;
  logic [1:0]  fill_way;
  logic [2:0]  fill_word;
  logic [31:0] fill_data;
  logic        refill_done;
  logic        refill_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  refill_ctrl #(.SET_ASSOC(4), .LINE_WORDS(8), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_way(hit_way),
    .miss_req(miss_req), .miss_addr(miss_addr), .set_valid(set_valid),
    .miss_ready(miss_ready), .repl_index(repl_index), .plru_access(plru_access),
    .plru_update(plru_update), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .fill_we(fill_we), .fill_way(fill_way),
    .fill_word(fill_word), .fill_data(fill_data), .refill_done(refill_done),
    .refill_err(refill_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one clock and drop all single-cycle input pulses.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    miss_req   = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    mem_rdata  = '0;
    hit_valid  = 1'b0;
    hit_way    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hit_valid = 1'b0; hit_way = '0; miss_req = 1'b0; miss_addr = '0;
    set_valid = '0; repl_index = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; mem_rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic drive_miss(input logic [31:0] addr, input logic [3:0] valid, input logic [1:0] repl);
    miss_req = 1'b1; miss_addr = addr; set_valid = valid; repl_index = repl;
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] data, input logic last);
    mem_rvalid = 1'b1; mem_rdata = data; mem_rlast = last;
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (miss_ready !== 1'b1) begin n_errors++; $display("FAIL reset_miss_ready: got %b expected 1", miss_ready); end
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (refill_done !== 1'b0 || refill_err !== 1'b0) begin n_errors++; $display("FAIL reset_done_err: got %b%b expected 00", refill_done, refill_err); end
    n_checks++; if (fill_we !== 1'b0 || fill_way !== 2'd0 || fill_word !== 3'd0) begin n_errors++; $display("FAIL reset_fill: got we=%b way=%0d word=%0d expected 0", fill_we, fill_way, fill_word); end
    n_checks++; if (plru_update !== 1'b0 || plru_access !== 4'b0) begin n_errors++; $display("FAIL reset_plru: got %b/%b expected 0/0000", plru_update, plru_access); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_invalid_way();
    drive_miss(32'h1234, 4'b1011, 2'd0);
    n_checks++; if (miss_ready !== 1'b1) begin n_errors++; $display("FAIL inv_accept_ready: got %b expected 1", miss_ready); end
    next_cycle();
    n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL inv_mem_req: got %b expected 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h1220) begin n_errors++; $display("FAIL inv_mem_addr: got %h expected 00001220", mem_addr); end
    n_checks++; if (fill_way !== 2'd2) begin n_errors++; $display("FAIL inv_fill_way: got %0d expected 2", fill_way); end
    n_checks++; if (miss_ready !== 1'b0) begin n_errors++; $display("FAIL inv_busy: got %b expected 0", miss_ready); end
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'hA0 + 32'(i), i == 7);
      n_checks++; if (fill_we !== 1'b1 || fill_word !== 3'(i)) begin n_errors++; $display("FAIL inv_beat%0d_we_word: got we=%b word=%0d expected we=1 word=%0d", i, fill_we, fill_word, i); end
      n_checks++; if (fill_data !== 32'hA0 + 32'(i)) begin n_errors++; $display("FAIL inv_beat%0d_data: got %h expected %h", i, fill_data, 32'hA0 + 32'(i)); end
      n_checks++; if (refill_done !== 1'b0 || plru_update !== 1'b0) begin n_errors++; $display("FAIL inv_beat%0d_quiet: got done=%b upd=%b expected 0/0", i, refill_done, plru_update); end
      next_cycle();
    end
    n_checks++; if (refill_done !== 1'b1 || plru_update !== 1'b1) begin n_errors++; $display("FAIL inv_commit: got done=%b upd=%b expected 1/1", refill_done, plru_update); end
    n_checks++; if (plru_access !== 4'b0100) begin n_errors++; $display("FAIL inv_commit_access: got %b expected 0100", plru_access); end
    n_checks++; if (refill_err !== 1'b0) begin n_errors++; $display("FAIL inv_err: got %b expected 0", refill_err); end
    next_cycle();
    n_checks++; if (miss_ready !== 1'b1 || refill_done !== 1'b0) begin n_errors++; $display("FAIL inv_idle: got ready=%b done=%b expected 1/0", miss_ready, refill_done); end
  endtask

  task automatic test_full_set();
    drive_miss(32'hDEADBEEF, 4'b1111, 2'd3);
    next_cycle();
    n_checks++; if (mem_addr !== 32'hDEADBEE0) begin n_errors++; $display("FAIL full_mem_addr: got %h expected deadbee0", mem_addr); end
    n_checks++; if (fill_way !== 2'd3) begin n_errors++; $display("FAIL full_fill_way: got %0d expected 3", fill_way); end
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'(i * 3 + 7), i == 7);
      n_checks++; if (fill_data !== 32'(i * 3 + 7) || fill_word !== 3'(i)) begin n_errors++; $display("FAIL full_beat%0d: got word=%0d data=%h expected word=%0d data=%h", i, fill_word, fill_data, i, 32'(i * 3 + 7)); end
      next_cycle();
    end
    n_checks++; if (refill_done !== 1'b1 || plru_access !== 4'b1000) begin n_errors++; $display("FAIL full_commit: got done=%b access=%b expected 1/1000", refill_done, plru_access); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    drive_miss(32'h40, 4'b0000, 2'd2);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_errors++; $display("FAIL bp_hold%0d: got req=%b addr=%h expected 1/00000040", c, mem_req, mem_addr); end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL bp_grant_req: got %b expected 1", mem_req); end
    next_cycle();
    n_checks++; if (mem_req !== 1'b0 || fill_way !== 2'd0) begin n_errors++; $display("FAIL bp_recv: got req=%b way=%0d expected 0/0", mem_req, fill_way); end
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (fill_we !== 1'b0) begin n_errors++; $display("FAIL bp_gap%0d_we: got %b expected 0", i, fill_we); end
      next_cycle();
      drive_beat(32'h5000 + 32'(i), i == 7);
      n_checks++; if (fill_we !== 1'b1 || fill_word !== 3'(i)) begin n_errors++; $display("FAIL bp_beat%0d: got we=%b word=%0d expected 1/%0d", i, fill_we, fill_word, i); end
      next_cycle();
    end
    n_checks++; if (refill_done !== 1'b1 || plru_access !== 4'b0001) begin n_errors++; $display("FAIL bp_commit: got done=%b access=%b expected 1/0001", refill_done, plru_access); end
    next_cycle();
    n_checks++; if (refill_done !== 1'b0) begin n_errors++; $display("FAIL bp_done_pulse: got %b expected 0", refill_done); end
  endtask

  task automatic test_hits();
    hit_valid = 1'b1; hit_way = 4'b0010;
    #1;
    n_checks++; if (plru_update !== 1'b1 || plru_access !== 4'b0010) begin n_errors++; $display("FAIL hit_idle: got %b/%b expected 1/0010", plru_update, plru_access); end
    next_cycle();
    hit_valid = 1'b1; hit_way = 4'b0110;
    #1;
    n_checks++; if (plru_access !== 4'b0110) begin n_errors++; $display("FAIL hit_invalid_fwd: got %b expected 0110", plru_access); end
    next_cycle();
    drive_miss(32'h2000, 4'b1101, 2'd3);
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin hit_valid = 1'b1; hit_way = 4'b0001; end
      drive_beat(32'h77, i == 7);
      if (i == 2) begin
        n_checks++; if (plru_update !== 1'b1 || plru_access !== 4'b0001) begin n_errors++; $display("FAIL hit_recv: got %b/%b expected 1/0001", plru_update, plru_access); end
      end else begin
        n_checks++; if (plru_update !== 1'b0) begin n_errors++; $display("FAIL hit_recv_quiet%0d: got %b expected 0", i, plru_update); end
      end
      next_cycle();
    end
    hit_valid = 1'b1; hit_way = 4'b0001;
    #1;
    n_checks++; if (plru_update !== 1'b1 || plru_access !== 4'b0010) begin n_errors++; $display("FAIL hit_commit: got %b/%b expected 1/0010", plru_update, plru_access); end
    next_cycle();
  endtask

  task automatic test_len_error();
    n_checks++; if (refill_err !== 1'b0) begin n_errors++; $display("FAIL err_pre: got %b expected 0", refill_err); end
    drive_miss(32'h3000, 4'b1111, 2'd1);
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      drive_beat(32'h10 + 32'(i), i == 5);
      next_cycle();
    end
    n_checks++; if (refill_done !== 1'b1 || refill_err !== 1'b1) begin n_errors++; $display("FAIL err_short: got done=%b err=%b expected 1/1", refill_done, refill_err); end
    n_checks++; if (plru_access !== 4'b0010) begin n_errors++; $display("FAIL err_short_access: got %b expected 0010", plru_access); end
    next_cycle();
    n_checks++; if (refill_err !== 1'b1 || miss_ready !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got err=%b ready=%b expected 1/1", refill_err, miss_ready); end
    do_reset();
    n_checks++; if (refill_err !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b expected 0", refill_err); end
    drive_miss(32'h3100, 4'b1111, 2'd0);
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h20 + 32'(i), 1'b0);
      n_checks++; if (fill_we !== 1'b1) begin n_errors++; $display("FAIL err_long_beat%0d: got %b expected 1", i, fill_we); end
      next_cycle();
    end
    drive_beat(32'h99, 1'b1);
    n_checks++; if (fill_we !== 1'b0) begin n_errors++; $display("FAIL err_ninth_beat: got %b expected 0", fill_we); end
    n_checks++; if (refill_done !== 1'b1 || refill_err !== 1'b1) begin n_errors++; $display("FAIL err_long: got done=%b err=%b expected 1/1", refill_done, refill_err); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_miss(32'h4000, 4'b0111, 2'd0);
    next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h30 + 32'(i), 1'b0);
      next_cycle();
    end
    drive_beat(32'h33, 1'b0);
    n_checks++; if (fill_we !== 1'b1 || fill_word !== 3'd3 || fill_way !== 2'd3) begin n_errors++; $display("FAIL arst_beat3: got we=%b word=%0d way=%0d expected 1/3/3", fill_we, fill_word, fill_way); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (dbg_state !== 2'd0 || miss_ready !== 1'b1) begin n_errors++; $display("FAIL arst_idle: got state=%0d ready=%b expected 0/1", dbg_state, miss_ready); end
    n_checks++; if (fill_we !== 1'b0 || fill_way !== 2'd0 || fill_word !== 3'd0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL arst_outputs: got we=%b way=%0d word=%0d req=%b expected 0", fill_we, fill_way, fill_word, mem_req); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    drive_miss(32'h105, 4'b1011, 2'd1);
    next_cycle();
    n_checks++; if (mem_addr !== 32'h100 || fill_way !== 2'd2) begin n_errors++; $display("FAIL arst_next_req: got addr=%h way=%0d expected 00000100/2", mem_addr, fill_way); end
    mem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h60 + 32'(i), i == 7);
      n_checks++; if (fill_word !== 3'(i) || fill_data !== 32'h60 + 32'(i)) begin n_errors++; $display("FAIL arst_next_beat%0d: got word=%0d data=%h expected %0d/%h", i, fill_word, fill_data, i, 32'h60 + 32'(i)); end
      next_cycle();
    end
    n_checks++; if (refill_done !== 1'b1 || plru_access !== 4'b0100 || refill_err !== 1'b0) begin n_errors++; $display("FAIL arst_next_commit: got done=%b access=%b err=%b expected 1/0100/0", refill_done, plru_access, refill_err); end
    next_cycle();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_invalid_way();
    test_full_set();
    test_backpressure();
    test_hits();
    test_len_error();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
